// File: rtl/control_unit.sv
// Control FSM for the 8-bit RISC machine: sequences fetch, decode and execute,
// driving every datapath/memory strobe combinationally from (state, instruction, Zflag).
module control_unit #(
    parameter int word_size  = 8,
    parameter int op_size    = 4,
    parameter int state_size = 4,
    parameter int src_size   = 2,
    parameter int dest_size  = 2,
    parameter int Sel1_size  = 3,
    parameter int Sel2_size  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 Zflag,
    output logic                 Load_R0,
    output logic                 Load_R1,
    output logic                 Load_R2,
    output logic                 Load_R3,
    output logic                 Load_PC,
    output logic                 Inc_PC,
    output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
    output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
    output logic                 Load_IR,
    output logic                 Load_Add_R,
    output logic                 Load_Reg_Y,
    output logic                 Load_Reg_Z,
    output logic                 write,
    output logic                 halted
);

    typedef enum logic [state_size-1:0] {
        S_idle = 4'd0,  S_fet1 = 4'd1,  S_fet2 = 4'd2, S_dec = 4'd3,
        S_ex1  = 4'd4,  S_rd1  = 4'd5,  S_rd2  = 4'd6, S_wr1 = 4'd7,
        S_wr2  = 4'd8,  S_br1  = 4'd9,  S_br2  = 4'd10, S_halt = 4'd11
    } state_t;

    localparam logic [op_size-1:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2,
                                   OP_AND = 4'd3, OP_NOT = 4'd4, OP_RD  = 4'd5,
                                   OP_WR  = 4'd6, OP_BR  = 4'd7, OP_BRZ = 4'd8;

    localparam logic [Sel1_size-1:0] SEL1_PC  = 3'd4;
    localparam logic [Sel2_size-1:0] SEL2_ALU = 2'd0, SEL2_BUS1 = 2'd1, SEL2_MEM = 2'd2;

    state_t                 r_state;
    state_t                 w_next;
    logic [op_size-1:0]     w_opcode;
    logic [src_size-1:0]    w_src;
    logic [dest_size-1:0]   w_dest;
    logic [3:0]             w_load_r;

    assign w_opcode = instruction[word_size-1 -: op_size];
    assign w_src    = instruction[src_size+dest_size-1 -: src_size];
    assign w_dest   = instruction[dest_size-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_idle;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next        = S_halt;
        w_load_r      = 4'b0000;
        Load_PC       = 1'b0;
        Inc_PC        = 1'b0;
        Sel_Bus_1_Mux = '0;
        Sel_Bus_2_Mux = '0;
        Load_IR       = 1'b0;
        Load_Add_R    = 1'b0;
        Load_Reg_Y    = 1'b0;
        Load_Reg_Z    = 1'b0;
        write         = 1'b0;
        halted        = 1'b0;
        case (r_state)
            S_idle: w_next = S_fet1;
            S_fet1: begin
                Sel_Bus_1_Mux = SEL1_PC;
                Sel_Bus_2_Mux = SEL2_BUS1;
                Load_Add_R    = 1'b1;
                w_next        = S_fet2;
            end
            S_fet2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_IR       = 1'b1;
                Inc_PC        = 1'b1;
                w_next        = S_dec;
            end
            S_dec: begin
                case (w_opcode)
                    OP_NOP: w_next = S_fet1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        Sel_Bus_1_Mux = {1'b0, w_src};
                        Sel_Bus_2_Mux = SEL2_BUS1;
                        Load_Reg_Y    = 1'b1;
                        w_next        = S_ex1;
                    end
                    OP_NOT: begin
                        Sel_Bus_1_Mux    = {1'b0, w_src};
                        Sel_Bus_2_Mux    = SEL2_ALU;
                        Load_Reg_Z       = 1'b1;
                        w_load_r[w_dest] = 1'b1;
                        w_next           = S_fet1;
                    end
                    OP_RD, OP_WR, OP_BR, OP_BRZ: begin
                        if (w_opcode == OP_BRZ && !Zflag) begin
                            // Not taken: step the PC over the branch-target byte.
                            Inc_PC = 1'b1;
                            w_next = S_fet1;
                        end else begin
                            Sel_Bus_1_Mux = SEL1_PC;
                            Sel_Bus_2_Mux = SEL2_BUS1;
                            Load_Add_R    = 1'b1;
                            case (w_opcode)
                                OP_RD:   w_next = S_rd1;
                                OP_WR:   w_next = S_wr1;
                                default: w_next = S_br1;
                            endcase
                        end
                    end
                    default: w_next = S_halt;
                endcase
            end
            S_ex1: begin
                Sel_Bus_1_Mux    = {1'b0, w_dest};
                Sel_Bus_2_Mux    = SEL2_ALU;
                Load_Reg_Z       = 1'b1;
                w_load_r[w_dest] = 1'b1;
                w_next           = S_fet1;
            end
            S_rd1, S_wr1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
                w_next        = (r_state == S_rd1) ? S_rd2 : S_wr2;
            end
            S_rd2: begin
                Sel_Bus_2_Mux    = SEL2_MEM;
                w_load_r[w_dest] = 1'b1;
                w_next           = S_fet1;
            end
            S_wr2: begin
                Sel_Bus_1_Mux = {1'b0, w_src};
                write         = 1'b1;
                w_next        = S_fet1;
            end
            S_br1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                w_next        = S_br2;
            end
            S_br2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_PC       = 1'b1;
                w_next        = S_fet1;
            end
            S_halt: begin
                halted = 1'b1;
                w_next = S_halt;
            end
            default: w_next = S_halt;
        endcase
    end

    assign Load_R0 = w_load_r[0];
    assign Load_R1 = w_load_r[1];
    assign Load_R2 = w_load_r[2];
    assign Load_R3 = w_load_r[3];

endmodule

// File: doc/control_unit.md
# control_unit

Control state machine for the 8-bit RISC stored-program machine. It sits opposite the processing-unit datapath. It consumes the datapath's `instruction` and `Zflag` outputs and drives every register-load, PC-increment, bus-mux-select and memory-write strobe that the datapath and memory accept. It sequences fetch, decode and execute for the nine-opcode instruction set and parks in a halt state on an illegal opcode.

## Interface
- `word_size`, 8: instruction width.
- `op_size`, 4: opcode field width, `instruction[7:4]`.
- `state_size`, 4: state register width.
- `src_size`, 2: source register field, `instruction[3:2]`.
- `dest_size`, 2: destination register field, `instruction[1:0]`.
- `Sel1_size`, 3: `Sel_Bus_1_Mux` width.
- `Sel2_size`, 2: `Sel_Bus_2_Mux` width.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `instruction` input 8: current instruction register contents.
- `Zflag` input 1: registered ALU zero flag.
- `Load_R0`, `Load_R1`, `Load_R2`, `Load_R3` output 1 each: register file load strobes.
- `Load_PC` output 1: load PC from Bus_2.
- `Inc_PC` output 1: PC increment.
- `Sel_Bus_1_Mux` output 3: Bus_1 source. 0=R0, 1=R1, 2=R2, 3=R3, 4=PC.
- `Sel_Bus_2_Mux` output 2: Bus_2 source. 0=ALU, 1=Bus_1, 2=mem_word.
- `Load_IR`, `Load_Add_R`, `Load_Reg_Y`, `Load_Reg_Z` output 1 each: datapath load strobes.
- `write` output 1: memory write enable. Data comes from Bus_1; the address comes from the address register.
- `halted` output 1: high while in S_halt.

## Operation
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Opcodes 9–15 are illegal.
- Only the state is registered. All outputs are combinational in (state, instruction, Zflag). Any strobe not listed for a state is 0, and both selects default to 0.
- States: S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_halt.

Per-state behaviour (outputs, then next state):
- S_idle: no outputs; next S_fet1.
- S_fet1: Sel1=PC, Sel2=Bus_1, Load_Add_R; next S_fet2.
- S_fet2: Sel2=mem, Load_IR, Inc_PC; next S_dec.
- S_dec, by opcode:
  - NOP: no outputs; next S_fet1.
  - ADD/SUB/AND: Sel1=src, Sel2=Bus_1, Load_Reg_Y; next S_ex1.
  - NOT: Sel1=src, Sel2=ALU, Load_Reg_Z, Load_R[dest]; next S_fet1.
  - RD/WR/BR: Sel1=PC, Sel2=Bus_1, Load_Add_R; next S_rd1, S_wr1 or S_br1 respectively.
  - BRZ with Zflag=1: same outputs as BR; next S_br1.
  - BRZ with Zflag=0: Inc_PC only (skips the address byte); next S_fet1.
  - Illegal opcode: no outputs; next S_halt.
- S_ex1: Sel1=dest, Sel2=ALU, Load_Reg_Z, Load_R[dest]; next S_fet1.
- S_rd1 and S_wr1: Sel2=mem, Load_Add_R, Inc_PC; next S_rd2 or S_wr2 respectively.
- S_rd2: Sel2=mem, Load_R[dest]; next S_fet1.
- S_wr2: Sel1=src, write; next S_fet1.
- S_br1: Sel2=mem, Load_Add_R; next S_br2.
- S_br2: Sel2=mem, Load_PC; next S_fet1.
- S_halt: `halted`=1, no other outputs. The only exit is reset.
- Unused state encodings must go to S_halt.
- Exactly one `Load_R*` is ever high, selected by the relevant field.
- `Load_PC` and `Inc_PC` are never high together.

## Timing
- Reset (`rst`=0, asynchronous) forces S_idle immediately. All outputs become 0, including `halted`, `Sel_Bus_1_Mux`=0 and `Sel_Bus_2_Mux`=0.
- Reset deassertion is sampled on `clk`. The first rising edge after `rst`=1 enters S_fet1.
- Reset asserted mid-instruction aborts that instruction. No further strobes are issued, and a partial RD/WR/BR leaves the PC wherever it already got to.
- Each state lasts exactly one cycle. Strobes are valid for the whole cycle and take effect at its closing edge.
- Cycles per instruction, from entry to S_fet1 to the next S_fet1:
  - NOP, NOT and BRZ not-taken: 3.
  - ADD, SUB, AND: 4.
  - RD, WR, BR and BRZ taken: 5.
- In S_dec, `Zflag` is the value registered by the previous ALU instruction. A BRZ immediately after ADD sees that ADD's flag.
- `write` is high for exactly one cycle per WR.

## Test plan
- Reset and fetch: assert `rst`=0 mid-cycle. All outputs go to 0 without a clock edge. Release reset, then check S_fet1 (Sel1=4, Sel2=1, Load_Add_R=1) and S_fet2 (Sel2=2, Load_IR=1, Inc_PC=1).
- ADD, `instruction`=8'h16 (src=R1, dest=R2): in S_dec, Sel1=1, Sel2=1, Load_Reg_Y=1. In S_ex1, Sel1=2, Sel2=0, Load_Reg_Z=1, Load_R2=1. Then back to S_fet1, 4 cycles total.
- RD, 8'h53 (dest=R3): 5-cycle sequence with Inc_PC in fet2 and rd1, and Load_R3=1 with Sel2=2 in rd2. WR, 8'h64 (src=R1): `write`=1 with Sel1=1 in wr2 only.
- BRZ, 8'h80: with Zflag=1, the br1/br2 path runs and Load_PC=1 with Sel2=2 in br2. With Zflag=0, S_dec shows Inc_PC=1 only, and S_fet1 follows after 3 cycles total.
- NOT, 8'h49 (src=R2, dest=R1): S_dec shows Sel1=2, Sel2=0, Load_Reg_Z=1, Load_R1=1 in a single cycle. NOP, 8'h00: S_dec drives all strobes 0.
- Illegal opcode 8'hF0: enters S_halt with `halted`=1 and stays for 20 cycles with every strobe 0. Asserting `rst`=0 clears `halted` immediately.
